// File: rtl/mprc_ptw_pkg.sv
// Shared constants, PTE layout and FSM encoding for the mprc_ptw page-table walker.
package mprc_ptw_pkg;

   localparam int PGIDX_BITS   = 12;
   localparam int VPN_LVL_BITS = 9;
   localparam int LEVELS       = 3;
   localparam int VPN_BITS     = LEVELS * VPN_LVL_BITS;
   localparam int ROOT_PPN_BITS = 20;
   localparam int PADDR_BITS   = 40;

   localparam int PTE_V_BIT   = 0;
   localparam int PTE_TYP_LO  = 1;
   localparam int PTE_TYP_HI  = 4;
   localparam int PTE_R_BIT   = 5;
   localparam int PTE_D_BIT   = 6;
   localparam int PTE_SW_LO   = 7;
   localparam int PTE_SW_HI   = 8;
   localparam int PTE_PPN_LO  = 10;
   localparam int PTE_PPN_HI  = 47;

   localparam logic [4:0] M_XRD = 5'h0;
   localparam logic [2:0] MT_D  = 3'h3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic [37:0] ppn;
      logic [1:0]  sw;
      logic        d;
      logic        r;
      logic [3:0]  typ;
      logic        v;
   } pte_t;

   function automatic pte_t decode_pte(input logic [63:0] w);
      pte_t p;
      p.v   = w[PTE_V_BIT];
      p.typ = w[PTE_TYP_HI:PTE_TYP_LO];
      p.r   = w[PTE_R_BIT];
      p.d   = w[PTE_D_BIT];
      p.sw  = w[PTE_SW_HI:PTE_SW_LO];
      p.ppn = w[PTE_PPN_HI:PTE_PPN_LO];
      return p;
   endfunction

   // Level 0 indexes with the most significant VPN slice.
   function automatic logic [VPN_LVL_BITS-1:0] vpn_idx(input logic [VPN_BITS-1:0] vpn,
                                                       input logic [1:0] lvl);
      case (lvl)
         2'd0:    return vpn[26:18];
         2'd1:    return vpn[17:9];
         default: return vpn[8:0];
      endcase
   endfunction

endpackage

// File: rtl/mprc_ptw.sv
// Three-level page-table walker: takes a TLB miss, loads PTEs through the dcache port,
// and returns the leaf (or an error) to the TLB.
module mprc_ptw
   import mprc_ptw_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] io_ptbr_ppn,
   input  logic        io_sptbr_write,
   output logic        io_ptw_req_ready,
   input  logic        io_ptw_req_valid,
   input  logic [26:0] io_ptw_req_bits_addr,
   input  logic [1:0]  io_ptw_req_bits_prv,
   input  logic        io_ptw_req_bits_store,
   input  logic        io_ptw_req_bits_fetch,
   output logic        io_ptw_resp_valid,
   output logic        io_ptw_resp_bits_error,
   output logic [37:0] io_ptw_resp_bits_pte_ppn,
   output logic [1:0]  io_ptw_resp_bits_pte_reserved_for_software,
   output logic        io_ptw_resp_bits_pte_d,
   output logic        io_ptw_resp_bits_pte_r,
   output logic [3:0]  io_ptw_resp_bits_pte_typ,
   output logic        io_ptw_resp_bits_pte_v,
   output logic        io_ptw_invalidate,
   input  logic        io_mem_req_ready,
   output logic        io_mem_req_valid,
   output logic [39:0] io_mem_req_bits_addr,
   output logic [4:0]  io_mem_req_bits_cmd,
   output logic [2:0]  io_mem_req_bits_typ,
   output logic        io_mem_req_bits_phys,
   output logic [8:0]  io_mem_req_bits_tag,
   input  logic        io_mem_s2_nack,
   input  logic        io_mem_resp_valid,
   input  logic [63:0] io_mem_resp_bits_data
);

   state_e                   state_q, state_d;
   logic [1:0]               lvl_q, lvl_d;
   logic [ROOT_PPN_BITS-1:0] ppn_q, ppn_d;
   logic [VPN_BITS-1:0]      vpn_q, vpn_d;
   logic [1:0]               prv_q, prv_d;
   logic                     store_q, store_d;
   logic                     fetch_q, fetch_d;
   pte_t                     resp_q, resp_d;
   logic                     err_q, err_d;
   logic                     inv_q, inv_d;

   pte_t mem_pte;
   logic is_ptr;
   logic last_lvl;

   assign mem_pte  = decode_pte(io_mem_resp_bits_data);
   assign is_ptr   = mem_pte.v && (mem_pte.typ < 4'd2);
   assign last_lvl = (lvl_q == 2'(LEVELS - 1));

   // NOTE: every always_comb target gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      ppn_d   = ppn_q;
      vpn_d   = vpn_q;
      prv_d   = prv_q;
      store_d = store_q;
      fetch_d = fetch_q;
      resp_d  = resp_q;
      err_d   = err_q;
      inv_d   = io_sptbr_write;

      case (state_q)
         S_IDLE: begin
            if (io_ptw_req_valid) begin
               vpn_d   = io_ptw_req_bits_addr;
               prv_d   = io_ptw_req_bits_prv;
               store_d = io_ptw_req_bits_store;
               fetch_d = io_ptw_req_bits_fetch;
               ppn_d   = io_ptbr_ppn;
               lvl_d   = 2'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (io_mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A nack wins over data arriving in the same cycle; the address is simply reissued.
            if (io_mem_s2_nack) begin
               state_d = S_REQ;
            end else if (io_mem_resp_valid) begin
               if (is_ptr && !last_lvl) begin
                  ppn_d   = mem_pte.ppn[ROOT_PPN_BITS-1:0];
                  lvl_d   = lvl_q + 2'd1;
                  state_d = S_REQ;
               end else begin
                  resp_d  = mem_pte;
                  err_d   = !mem_pte.v || is_ptr;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lvl_q   <= 2'd0;
         ppn_q   <= '0;
         vpn_q   <= '0;
         prv_q   <= '0;
         store_q <= 1'b0;
         fetch_q <= 1'b0;
         resp_q  <= '0;
         err_q   <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         ppn_q   <= ppn_d;
         vpn_q   <= vpn_d;
         prv_q   <= prv_d;
         store_q <= store_d;
         fetch_q <= fetch_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
         inv_q   <= inv_d;
      end
   end

   // NOTE: handshake outputs are gated by reset so they stay low for the whole reset cycle,
   // not just once the state register has been cleared.
   assign io_ptw_req_ready  = !reset && (state_q == S_IDLE);
   assign io_mem_req_valid  = !reset && (state_q == S_REQ);
   assign io_ptw_resp_valid = !reset && (state_q == S_DONE);
   assign io_ptw_invalidate = !reset && inv_q;

   assign io_mem_req_bits_addr = {8'h0, ppn_q, vpn_idx(vpn_q, lvl_q),
                                  {(PGIDX_BITS - VPN_LVL_BITS){1'b0}}};
   assign io_mem_req_bits_cmd  = M_XRD;
   assign io_mem_req_bits_typ  = MT_D;
   assign io_mem_req_bits_phys = 1'b1;
   assign io_mem_req_bits_tag  = 9'h0;

   assign io_ptw_resp_bits_error                     = err_q;
   assign io_ptw_resp_bits_pte_ppn                   = resp_q.ppn;
   assign io_ptw_resp_bits_pte_reserved_for_software = resp_q.sw;
   assign io_ptw_resp_bits_pte_d                     = resp_q.d;
   assign io_ptw_resp_bits_pte_r                     = resp_q.r;
   assign io_ptw_resp_bits_pte_typ                   = resp_q.typ;
   assign io_ptw_resp_bits_pte_v                     = resp_q.v;

   // Privilege/access flags are held for the TLB's benefit only; ignored PTE bits are dropped.
   logic unused_ok;
   assign unused_ok = ^{prv_q, store_q, fetch_q, io_mem_resp_bits_data[63:48],
                        io_mem_resp_bits_data[9]};

endmodule

// File: tb/tb_mprc_ptw.sv
// Self-checking bench for mprc_ptw: directed walks plus randomized walks against a
// behavioural page-table walk over a sparse memory image.
module tb_mprc_ptw;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] io_ptbr_ppn;
   logic        io_sptbr_write;
   logic        io_ptw_req_ready;
   logic        io_ptw_req_valid;
   logic [26:0] io_ptw_req_bits_addr;
   logic [1:0]  io_ptw_req_bits_prv;
   logic        io_ptw_req_bits_store;
   logic        io_ptw_req_bits_fetch;
   logic        io_ptw_resp_valid;
   logic        io_ptw_resp_bits_error;
   logic [37:0] io_ptw_resp_bits_pte_ppn;
   logic [1:0]  io_ptw_resp_bits_pte_reserved_for_software;
   logic        io_ptw_resp_bits_pte_d;
   logic        io_ptw_resp_bits_pte_r;
   logic [3:0]  io_ptw_resp_bits_pte_typ;
   logic        io_ptw_resp_bits_pte_v;
   logic        io_ptw_invalidate;
   logic        io_mem_req_ready;
   logic        io_mem_req_valid;
   logic [39:0] io_mem_req_bits_addr;
   logic [4:0]  io_mem_req_bits_cmd;
   logic [2:0]  io_mem_req_bits_typ;
   logic        io_mem_req_bits_phys;
   logic [8:0]  io_mem_req_bits_tag;
   logic        io_mem_s2_nack;
   logic        io_mem_resp_valid;
   logic [63:0] io_mem_resp_bits_data;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [logic [39:0]];
   logic [39:0] exp_addrs [$];
   logic [39:0] got_addrs [$];
   bit          exp_err;
   logic [63:0] exp_word;

   always #5 clk = ~clk;

   mprc_ptw dut (
      .clk(clk),
      .reset(reset),
      .io_ptbr_ppn(io_ptbr_ppn),
      .io_sptbr_write(io_sptbr_write),
      .io_ptw_req_ready(io_ptw_req_ready),
      .io_ptw_req_valid(io_ptw_req_valid),
      .io_ptw_req_bits_addr(io_ptw_req_bits_addr),
      .io_ptw_req_bits_prv(io_ptw_req_bits_prv),
      .io_ptw_req_bits_store(io_ptw_req_bits_store),
      .io_ptw_req_bits_fetch(io_ptw_req_bits_fetch),
      .io_ptw_resp_valid(io_ptw_resp_valid),
      .io_ptw_resp_bits_error(io_ptw_resp_bits_error),
      .io_ptw_resp_bits_pte_ppn(io_ptw_resp_bits_pte_ppn),
      .io_ptw_resp_bits_pte_reserved_for_software(io_ptw_resp_bits_pte_reserved_for_software),
      .io_ptw_resp_bits_pte_d(io_ptw_resp_bits_pte_d),
      .io_ptw_resp_bits_pte_r(io_ptw_resp_bits_pte_r),
      .io_ptw_resp_bits_pte_typ(io_ptw_resp_bits_pte_typ),
      .io_ptw_resp_bits_pte_v(io_ptw_resp_bits_pte_v),
      .io_ptw_invalidate(io_ptw_invalidate),
      .io_mem_req_ready(io_mem_req_ready),
      .io_mem_req_valid(io_mem_req_valid),
      .io_mem_req_bits_addr(io_mem_req_bits_addr),
      .io_mem_req_bits_cmd(io_mem_req_bits_cmd),
      .io_mem_req_bits_typ(io_mem_req_bits_typ),
      .io_mem_req_bits_phys(io_mem_req_bits_phys),
      .io_mem_req_bits_tag(io_mem_req_bits_tag),
      .io_mem_s2_nack(io_mem_s2_nack),
      .io_mem_resp_valid(io_mem_resp_valid),
      .io_mem_resp_bits_data(io_mem_resp_bits_data)
   );

   function automatic logic [63:0] mem_rd(input logic [39:0] a);
      return mem.exists(a) ? mem[a] : 64'h0;
   endfunction

   function automatic logic [63:0] mk_pte(input bit v, input logic [3:0] typ,
                                          input logic [37:0] ppn, input bit noisy);
      logic [63:0] w;
      w = noisy ? {$urandom, $urandom} : 64'h0;
      w[0]     = v;
      w[4:1]   = typ;
      w[47:10] = ppn;
      return w;
   endfunction

   // Reference walk: page base = ppn * 4 KiB, entry = 8 bytes * 9-bit VPN slice.
   task automatic model_walk(input logic [19:0] ptbr, input logic [26:0] vpn);
      longint unsigned base;
      longint unsigned idx;
      logic [63:0]     w;
      exp_addrs.delete();
      base = longint'(ptbr) * 4096;
      for (int l = 0; l < 3; l++) begin
         idx = (longint'(vpn) >> (9 * (2 - l))) % 512;
         exp_addrs.push_back(40'(base + idx * 8));
         w = mem_rd(40'(base + idx * 8));
         exp_word = w;
         if (w[0] == 1'b0) begin
            exp_err = 1'b1;
            return;
         end
         if (w[4:1] >= 4'd2) begin
            exp_err = 1'b0;
            return;
         end
         if (l == 2) begin
            exp_err = 1'b1;
            return;
         end
         base = longint'(w[29:10]) * 4096;
      end
   endtask

   task automatic idle_inputs();
      io_ptw_req_valid      = 1'b0;
      io_sptbr_write        = 1'b0;
      io_mem_req_ready      = 1'b0;
      io_mem_s2_nack        = 1'b0;
      io_mem_resp_valid     = 1'b0;
      io_mem_resp_bits_data = 64'h0;
   endtask

   // Drives one walk cycle by cycle, acting as the TLB and the dcache, checking as it goes.
   task automatic run_walk(input logic [19:0] ptbr, input logic [26:0] vpn, input int nack_at,
                           input bit jitter, input int sptbr_at, input bit check_latency);
      int          acc_idx  = 0;
      bit          pending  = 1'b0;
      bit          nacked   = 1'b0;
      int          resp_seen = 0;
      int          done_cyc = -1;
      bit          inv_exp  = 1'b0;
      bit          req_fire, mem_fire, gave_nack, gave_resp;
      logic [39:0] last_addr = '0;
      logic [39:0] ea;
      bit          exp_ready;
      model_walk(ptbr, vpn);
      got_addrs.delete();
      io_ptbr_ppn           = ptbr;
      io_ptw_req_bits_addr  = vpn;
      io_ptw_req_bits_prv   = 2'($urandom);
      io_ptw_req_bits_store = 1'($urandom);
      io_ptw_req_bits_fetch = 1'($urandom);
      io_ptw_req_valid      = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         checks++;
         if (io_ptw_invalidate !== inv_exp) begin
            errors++;
            $display("FAIL invalidate cyc=%0d got=%b exp=%b", cyc, io_ptw_invalidate, inv_exp);
         end
         exp_ready = (cyc == 0) || (done_cyc >= 0);
         checks++;
         if (io_ptw_req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, io_ptw_req_ready, exp_ready);
         end
         if (io_ptw_resp_valid === 1'b1) begin
            resp_seen++;
            done_cyc = cyc;
            checks++;
            if (io_ptw_resp_bits_error !== exp_err || io_ptw_resp_bits_pte_ppn !== exp_word[47:10] ||
                io_ptw_resp_bits_pte_reserved_for_software !== exp_word[8:7] ||
                io_ptw_resp_bits_pte_d !== exp_word[6] || io_ptw_resp_bits_pte_r !== exp_word[5] ||
                io_ptw_resp_bits_pte_typ !== exp_word[4:1] || io_ptw_resp_bits_pte_v !== exp_word[0]) begin
               errors++;
               $display("FAIL resp_fields got err=%b ppn=%h typ=%h v=%b exp err=%b ppn=%h typ=%h v=%b",
                        io_ptw_resp_bits_error, io_ptw_resp_bits_pte_ppn, io_ptw_resp_bits_pte_typ,
                        io_ptw_resp_bits_pte_v, exp_err, exp_word[47:10], exp_word[4:1], exp_word[0]);
            end
         end else if (done_cyc >= 0) begin
            checks++;
            if (io_ptw_resp_bits_pte_ppn !== exp_word[47:10] || io_ptw_resp_bits_error !== exp_err) begin
               errors++;
               $display("FAIL resp_hold got ppn=%h err=%b exp ppn=%h err=%b",
                        io_ptw_resp_bits_pte_ppn, io_ptw_resp_bits_error, exp_word[47:10], exp_err);
            end
         end
         if (io_mem_req_valid === 1'b1) begin
            ea = (acc_idx < exp_addrs.size()) ? exp_addrs[acc_idx] : 40'hFF_FFFF_FFFF;
            checks++;
            if (io_mem_req_bits_addr !== ea) begin
               errors++;
               $display("FAIL mem_addr access=%0d got=%h exp=%h", acc_idx, io_mem_req_bits_addr, ea);
            end
            checks++;
            if (io_mem_req_bits_cmd !== 5'h0 || io_mem_req_bits_typ !== 3'h3 ||
                io_mem_req_bits_phys !== 1'b1 || io_mem_req_bits_tag !== 9'h0) begin
               errors++;
               $display("FAIL mem_consts got cmd=%h typ=%h phys=%b tag=%h exp 0/3/1/0",
                        io_mem_req_bits_cmd, io_mem_req_bits_typ, io_mem_req_bits_phys,
                        io_mem_req_bits_tag);
            end
         end
         // Inputs for the coming edge.
         io_sptbr_write   = (cyc == sptbr_at);
         io_mem_req_ready = io_mem_req_valid && (!jitter || $urandom_range(0, 2) != 0);
         io_mem_s2_nack   = 1'b0;
         if (pending) begin
            if (acc_idx == nack_at && !nacked) begin
               io_mem_s2_nack        = 1'b1;
               io_mem_resp_valid     = 1'($urandom);
               io_mem_resp_bits_data = {$urandom, $urandom};
               nacked                = 1'b1;
            end else if (!jitter || $urandom_range(0, 1) == 0) begin
               io_mem_resp_valid     = 1'b1;
               io_mem_resp_bits_data = mem_rd(last_addr);
            end else begin
               io_mem_resp_valid = 1'b0;
            end
         end else begin
            io_mem_resp_valid     = jitter && ($urandom_range(0, 3) == 0);
            io_mem_resp_bits_data = {$urandom, $urandom};
         end
         req_fire  = io_ptw_req_valid && io_ptw_req_ready;
         mem_fire  = io_mem_req_valid && io_mem_req_ready;
         gave_nack = pending && io_mem_s2_nack;
         gave_resp = pending && io_mem_resp_valid && !io_mem_s2_nack;
         if (mem_fire) last_addr = io_mem_req_bits_addr;
         @(posedge clk);
         #1;
         inv_exp = (cyc == sptbr_at);
         if (req_fire) begin
            io_ptw_req_valid     = 1'b0;
            io_ptbr_ppn          = 20'($urandom);
            io_ptw_req_bits_addr = 27'($urandom);
         end
         if (gave_nack || gave_resp) pending = 1'b0;
         if (gave_resp) acc_idx++;
         if (mem_fire) begin
            pending = 1'b1;
            got_addrs.push_back(last_addr);
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      idle_inputs();
      checks++;
      if (resp_seen != 1) begin
         errors++;
         $display("FAIL resp_count got=%0d exp=1", resp_seen);
      end
      checks++;
      if (acc_idx != exp_addrs.size()) begin
         errors++;
         $display("FAIL access_count got=%0d exp=%0d", acc_idx, exp_addrs.size());
      end
      if (check_latency) begin
         checks++;
         if (done_cyc != 7) begin
            errors++;
            $display("FAIL latency got=%0d exp=7", done_cyc);
         end
      end
   endtask

   task automatic check_addrs(input string name, input logic [39:0] e0, input logic [39:0] e1,
                              input logic [39:0] e2, input logic [39:0] e3, input int n);
      logic [39:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      checks++;
      if (got_addrs.size() != n) begin
         errors++;
         $display("FAIL %s_count got=%0d exp=%0d", name, got_addrs.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (got_addrs[i] !== e[i]) begin
               errors++;
               $display("FAIL %s[%0d] got=%h exp=%h", name, i, got_addrs[i], e[i]);
            end
         end
      end
   endtask

   task automatic load_basic_table();
      mem.delete();
      mem[40'h100000] = mk_pte(1'b1, 4'd0, 38'h200, 1'b0);
      mem[40'h200000] = mk_pte(1'b1, 4'd0, 38'h300, 1'b0);
      mem[40'h300008] = mk_pte(1'b1, 4'd2, 38'hABC, 1'b0);
   endtask

   task automatic test_reset();
      idle_inputs();
      io_ptbr_ppn = '0;
      io_ptw_req_bits_addr = '0;
      io_ptw_req_bits_prv = '0;
      io_ptw_req_bits_store = 1'b0;
      io_ptw_req_bits_fetch = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (io_ptw_req_ready !== 1'b0 || io_mem_req_valid !== 1'b0 || io_ptw_resp_valid !== 1'b0 ||
          io_ptw_invalidate !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b memv=%b respv=%b inv=%b exp all 0",
                  io_ptw_req_ready, io_mem_req_valid, io_ptw_resp_valid, io_ptw_invalidate);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (io_ptw_req_ready !== 1'b1 || io_ptw_resp_bits_error !== 1'b0 ||
          io_ptw_resp_bits_pte_ppn !== 38'h0) begin
         errors++;
         $display("FAIL post_reset got rdy=%b err=%b ppn=%h exp 1/0/0",
                  io_ptw_req_ready, io_ptw_resp_bits_error, io_ptw_resp_bits_pte_ppn);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_walk();
      load_basic_table();
      run_walk(20'h00100, 27'h0000001, -1, 1'b0, -1, 1'b1);
      check_addrs("basic_addr", 40'h100000, 40'h200000, 40'h300008, 40'h0, 3);
   endtask

   task automatic test_invalid_root();
      mem.delete();
      mem[40'h100000] = mk_pte(1'b0, 4'd2, 38'h123, 1'b1);
      run_walk(20'h00100, 27'h0000001, -1, 1'b0, -1, 1'b0);
      check_addrs("invalid_addr", 40'h100000, 40'h0, 40'h0, 40'h0, 1);
   endtask

   task automatic test_pointer_at_last_level();
      load_basic_table();
      mem[40'h300008] = mk_pte(1'b1, 4'd1, 38'h777, 1'b0);
      run_walk(20'h00100, 27'h0000001, -1, 1'b0, -1, 1'b0);
      check_addrs("ptr_l2_addr", 40'h100000, 40'h200000, 40'h300008, 40'h0, 3);
   endtask

   task automatic test_nack();
      load_basic_table();
      run_walk(20'h00100, 27'h0000001, 1, 1'b0, -1, 1'b0);
      check_addrs("nack_addr", 40'h100000, 40'h200000, 40'h200000, 40'h300008, 4);
   endtask

   task automatic test_sptbr_write();
      load_basic_table();
      run_walk(20'h00100, 27'h0000001, -1, 1'b0, 3, 1'b0);
   endtask

   task automatic test_reset_mid_walk();
      load_basic_table();
      io_ptbr_ppn          = 20'h00100;
      io_ptw_req_bits_addr = 27'h0000001;
      io_ptw_req_valid     = 1'b1;
      @(posedge clk);
      #1;
      io_ptw_req_valid = 1'b0;
      io_mem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      io_mem_req_ready = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (io_ptw_req_ready !== 1'b0 || io_mem_req_valid !== 1'b0 || io_ptw_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_wait got rdy=%b memv=%b respv=%b exp 0/0/0",
                  io_ptw_req_ready, io_mem_req_valid, io_ptw_resp_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (io_ptw_req_ready !== 1'b0 || io_ptw_resp_bits_pte_ppn !== 38'h0 ||
          io_ptw_resp_bits_pte_v !== 1'b0) begin
         errors++;
         $display("FAIL reset_cycle got rdy=%b ppn=%h v=%b exp 0/0/0",
                  io_ptw_req_ready, io_ptw_resp_bits_pte_ppn, io_ptw_resp_bits_pte_v);
      end
      reset                 = 1'b0;
      io_mem_resp_valid     = 1'b1;
      io_mem_resp_bits_data = mk_pte(1'b1, 4'd2, 38'h55, 1'b0);
      #1;
      checks++;
      if (io_ptw_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got=%b exp=1", io_ptw_req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         io_mem_resp_valid = 1'b0;
         checks++;
         if (io_ptw_resp_valid !== 1'b0 || io_mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_resp cyc=%0d got respv=%b memv=%b exp 0/0",
                     i, io_ptw_resp_valid, io_mem_req_valid);
         end
      end
      idle_inputs();
   endtask

   task automatic test_random_walks();
      logic [19:0] ptbr;
      logic [26:0] vpn;
      logic [19:0] cur;
      logic [39:0] a;
      int          kind;
      logic [37:0] nppn;
      for (int n = 0; n < 40; n++) begin
         mem.delete();
         ptbr = 20'($urandom_range(0, 16'hFFFF));
         vpn  = 27'($urandom);
         cur  = ptbr;
         for (int l = 0; l < 3; l++) begin
            a    = 40'((longint'(cur) * 4096) + ((longint'(vpn) >> (9 * (2 - l))) % 512) * 8);
            kind = $urandom_range(0, 9);
            nppn = {$urandom, $urandom};
            nppn[19:16] = 4'(l + 1);
            if (kind == 0) begin
               mem[a] = mk_pte(1'b0, 4'($urandom), nppn, 1'b1);
               break;
            end else if (kind <= 5) begin
               mem[a] = mk_pte(1'b1, 4'($urandom_range(0, 1)), nppn, 1'b1);
               cur    = nppn[19:0];
            end else begin
               mem[a] = mk_pte(1'b1, 4'($urandom_range(2, 15)), nppn, 1'b1);
               break;
            end
         end
         run_walk(ptbr, vpn, $urandom_range(0, 5) - 2, 1'b1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_walk();
      test_invalid_root();
      test_pointer_at_last_level();
      test_nack();
      test_sptbr_write();
      test_reset_mid_walk();
      test_random_walks();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
